// File: rtl/jtvigil_pcm_multich_if.sv
// PCM ROM request port: the sequencer drives cs/addr, the ROM answers data/ok.
// Latency: set by the ROM; the sequencer holds rom_addr until rom_ok.
// Backpressure: rom_ok low stalls the fetch for as long as it stays low.
interface jtvigil_pcm_multich_if #(
  parameter int AW = 16
);
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (output rom_cs, rom_addr, input rom_data, rom_ok);
  modport slave  (input rom_cs, rom_addr, output rom_data, rom_ok);
endinterface

// File: rtl/jtvigil_pcm_multich.sv
// Multi-channel PCM sequencer: per-channel start/end/loop/volume, round-robin ROM fetch, saturated mix.
// Latency: zero-wait ROM gives the sample pulse 2*N+2 cycles after the strobe cycle (N playing channels).
// Backpressure: rom_ok stalls the fetch; a strobe arriving while busy sets overrun and merges into pending.
module jtvigil_pcm_multich #(
  parameter int CHW    = 1,
  parameter int AW     = 16,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_cen,
  input  logic                wr,
  input  logic [CHW+2:0]      wr_addr,
  input  logic [7:0]          din,
  output logic [2**CHW:0]     status,
  input  logic                ovr_clr,
  jtvigil_pcm_multich_if.master rom,
  output logic signed [15:0]  snd,
  output logic                sample
);
  localparam int CH  = 2**CHW;
  localparam int ACW = CHW + 16;
  localparam logic signed [ACW-1:0] PMAX = ACW'(32767);
  localparam logic signed [ACW-1:0] NMIN = ACW'(-32768);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, MIX} state_t;

  state_t           state, state_nx;
  logic [CHW-1:0]   sel, sel_nx;
  logic [AW-1:0]    start_a [CH];
  logic [AW-1:0]    end_a   [CH];
  logic [AW-1:0]    cur_a   [CH];
  logic [7:0]       vol     [CH];
  logic signed [7:0] smp    [CH];
  logic [CH-1:0]    play, loop_en, pending, pend_nx;
  logic             overrun;
  logic [AW-1:0]    rom_addr_r;
  logic [CHW-1:0]   wr_ch;
  logic [2:0]       reg_sel;
  logic             done;
  logic signed [7:0] smp_in;
  logic signed [ACW-1:0] acc;
  logic signed [16:0]    prod;
  logic signed [15:0]    sat;

  assign wr_ch   = wr_addr[CHW+2:3];
  assign reg_sel = wr_addr[2:0];
  assign done    = (state == WAIT) && rom.rom_ok;
  // Offset-binary ROM data becomes two's complement by flipping the MSB.
  assign smp_in  = (SIGNED != 0) ? rom.rom_data : {~rom.rom_data[7], rom.rom_data[6:0]};

  assign rom.rom_cs   = (state == ADDR) || (state == WAIT);
  assign rom.rom_addr = rom_addr_r;
  assign status       = {overrun, play};

  function automatic logic [CHW-1:0] lowest(input logic [CH-1:0] v);
    lowest = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (v[i]) lowest = CHW'(i);
    end
  endfunction

  // Pending set after this edge: completed fetch clears, a strobe re-arms every playing channel.
  always_comb begin
    pend_nx = pending;
    if (done) pend_nx[sel] = 1'b0;
    if (sample_cen) pend_nx = pend_nx | play;
  end

  // Next state and channel select; lowest pending index is always served first.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    case (state)
      IDLE: if (|pend_nx) begin
        state_nx = ADDR;
        sel_nx   = lowest(pend_nx);
      end
      ADDR: state_nx = WAIT;
      WAIT: if (rom.rom_ok) begin
        if (|pend_nx) begin
          state_nx = ADDR;
          sel_nx   = lowest(pend_nx);
        end else begin
          state_nx = MIX;
        end
      end
      MIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Volume-weighted sum of held samples, clamped to the 16-bit output range.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int i = 0; i < CH; i++) begin
      prod = 17'(smp[i]) * 17'($signed({1'b0, vol[i]}));
      acc  = acc + ACW'(prod);
    end
    if (acc > PMAX)      sat = 16'sh7fff;
    else if (acc < NMIN) sat = -16'sh8000;
    else                 sat = acc[15:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
    end
  end

  // Channel registers, fetch capture, address advance and mix output; register writes take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      play       <= '0;
      loop_en    <= '0;
      pending    <= '0;
      overrun    <= 1'b0;
      rom_addr_r <= '0;
      snd        <= '0;
      sample     <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        start_a[i] <= '0;
        end_a[i]   <= '0;
        cur_a[i]   <= '0;
        vol[i]     <= '0;
        smp[i]     <= '0;
      end
    end else begin
      pending <= pend_nx;
      if (sample_cen && state != IDLE) overrun <= 1'b1;
      else if (ovr_clr)                overrun <= 1'b0;
      sample <= (state == MIX);
      if (state == ADDR) rom_addr_r <= cur_a[sel];
      if (state == MIX)  snd <= sat;
      for (int i = 0; i < CH; i++) begin
        // A channel that has stopped keeps its last sample for one mix, then goes silent.
        if (state == MIX && !play[i]) smp[i] <= '0;
        if (done && sel == CHW'(i)) begin
          if (play[i]) begin
            smp[i] <= smp_in;
            if (cur_a[i] == end_a[i]) begin
              if (loop_en[i]) cur_a[i] <= start_a[i];
              else            play[i]  <= 1'b0;
            end else begin
              cur_a[i] <= cur_a[i] + AW'(1);
            end
          end else begin
            smp[i] <= '0;
          end
        end
        if (wr && wr_ch == CHW'(i)) begin
          case (reg_sel)
            3'd0: start_a[i] <= {start_a[i][AW-1:8], din};
            3'd1: start_a[i] <= {din[AW-9:0], start_a[i][7:0]};
            3'd2: end_a[i]   <= {end_a[i][AW-1:8], din};
            3'd3: end_a[i]   <= {din[AW-9:0], end_a[i][7:0]};
            3'd4: begin
              loop_en[i] <= din[1];
              play[i]    <= din[0];
              if (din[0]) cur_a[i] <= start_a[i];
              else        smp[i]   <= '0;
            end
            3'd5:    vol[i] <= din;
            default: ;
          endcase
        end
      end
    end
  end
endmodule
